// File: rtl/cdp1802_dma_out.sv
// CDP1802 machine-cycle sequencer with CDP1861 DMA-OUT (S2) responder.
// Generates TPA/TPB and SC, arbitrates each cycle between the CPU and S2, and fetches video bytes at R0.
module cdp1802_dma_out #(
    parameter int          RAM_LAT  = 1,
    parameter logic [15:0] R0_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        dmao_req,
    input  logic [1:0]  cpu_sc,
    input  logic        r0_load,
    input  logic [15:0] r0_din,
    output logic        ram_rd,
    output logic [15:0] ram_a,
    input  logic [7:0]  ram_q,
    output logic [7:0]  dma_data,
    output logic        tpa,
    output logic        tpb,
    output logic [1:0]  sc,
    output logic        cpu_step,
    output logic        dma_active,
    output logic [15:0] r0
);

    localparam logic [2:0] PH_TPA  = 3'd1;
    localparam logic [2:0] PH_READ = 3'd2;
    localparam logic [2:0] PH_TPB  = 3'd6;
    localparam logic [2:0] PH_LAST = 3'd7;

    localparam logic [1:0] SC_FETCH = 2'b00;
    localparam logic [1:0] SC_DMA   = 2'b10;

    logic [2:0]         ph;
    logic               cycle_end;
    logic [15:0]        r0_next;
    logic               pend_valid;
    logic [15:0]        pend_data;
    logic [RAM_LAT-1:0] rd_pipe;

    assign cycle_end = ce && (ph == PH_LAST);
    assign tpa       = (ph == PH_TPA);
    assign tpb       = (ph == PH_TPB);
    assign ram_rd    = dma_active && ce && (ph == PH_READ);
    assign cpu_step  = !dma_active && cycle_end;

    // During S2 a CPU load is deferred to the cycle end, where it beats the post-increment.
    always_comb begin
        // NOTE: default first so every path assigns r0_next and no latch is inferred.
        r0_next = r0;
        if (dma_active) begin
            if (cycle_end) begin
                if (r0_load)
                    r0_next = r0_din;
                else if (pend_valid)
                    r0_next = pend_data;
                else
                    r0_next = r0 + 16'd1;
            end
        end else if (r0_load) begin
            r0_next = r0_din;
        end
    end

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ph <= 3'd0;
        else if (ce)
            ph <= ph + 3'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sc         <= SC_FETCH;
            dma_active <= 1'b0;
            ram_a      <= 16'h0000;
        end else if (cycle_end) begin
            dma_active <= dmao_req;
            sc         <= dmao_req ? SC_DMA : cpu_sc;
            if (dmao_req)
                ram_a <= r0_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r0         <= R0_RESET;
            pend_valid <= 1'b0;
        end else begin
            r0 <= r0_next;
            if (dma_active && cycle_end)
                pend_valid <= 1'b0;
            else if (dma_active && r0_load)
                pend_valid <= 1'b1;
        end
    end

    // NOTE: pend_data is only consumed while pend_valid is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (dma_active && r0_load)
            pend_data <= r0_din;
    end

    // The capture is timed in raw clocks from the read strobe, independent of ce.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= ram_rd;
            for (int i = 1; i < RAM_LAT; i++)
                rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            dma_data <= 8'h00;
        else if (rd_pipe[RAM_LAT-1])
            dma_data <= ram_q;
    end

endmodule

// File: tb/tb_cdp1802_dma_out.sv
// Bench for cdp1802_dma_out: two instances (RAM_LAT 1 and 2) checked every clk against a cycle-level model.
module tb_cdp1802_dma_out;

    localparam logic [15:0] R0_RST = 16'hC0DE;

    logic        clk = 1'b0;
    logic        reset, ce, dmao_req, r0_load;
    logic [1:0]  cpu_sc;
    logic [15:0] r0_din;

    logic [1:0]        ram_rd, tpa, tpb, cpu_step, dma_active;
    logic [1:0][15:0]  ram_a, r0;
    logic [1:0][7:0]   ram_q, dma_data;
    logic [1:0][1:0]   sc;

    cdp1802_dma_out #(.RAM_LAT(1), .R0_RESET(R0_RST)) dut_lat1 (
        .clk(clk), .reset(reset), .ce(ce), .dmao_req(dmao_req), .cpu_sc(cpu_sc),
        .r0_load(r0_load), .r0_din(r0_din), .ram_rd(ram_rd[0]), .ram_a(ram_a[0]),
        .ram_q(ram_q[0]), .dma_data(dma_data[0]), .tpa(tpa[0]), .tpb(tpb[0]), .sc(sc[0]),
        .cpu_step(cpu_step[0]), .dma_active(dma_active[0]), .r0(r0[0])
    );

    cdp1802_dma_out #(.RAM_LAT(2), .R0_RESET(R0_RST)) dut_lat2 (
        .clk(clk), .reset(reset), .ce(ce), .dmao_req(dmao_req), .cpu_sc(cpu_sc),
        .r0_load(r0_load), .r0_din(r0_din), .ram_rd(ram_rd[1]), .ram_a(ram_a[1]),
        .ram_q(ram_q[1]), .dma_data(dma_data[1]), .tpa(tpa[1]), .tpb(tpb[1]), .sc(sc[1]),
        .cpu_step(cpu_step[1]), .dma_active(dma_active[1]), .r0(r0[1])
    );

    always #5 clk = ~clk;

    int passes = 0;
    int checks = 0;
    bit mode = 1'b0;
    bit started = 1'b0;
    int ce_div = 1;
    int tick_n = 0;
    int step_cnt [2];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s[%0d] got %h expected %h at %0t", name, idx, act, exp, $time);
    endtask

    function automatic logic [7:0] ram_f(input logic [15:0] a);
        return mode ? (a[7:0] ^ a[15:8] ^ 8'h5A) : a[7:0];
    endfunction

    // Video RAM models: data valid exactly RAM_LAT clks after the read, noise otherwise.
    logic        v_l2;
    logic [15:0] a_l2;
    always @(posedge clk) begin
        ram_q[0] <= ram_rd[0] ? ram_f(ram_a[0]) : 8'($urandom);
        v_l2     <= ram_rd[1];
        a_l2     <= ram_a[1];
        ram_q[1] <= v_l2 ? ram_f(a_l2) : 8'($urandom);
    end

    // Cycle-level reference: phase = count of enabled clks mod 8, one record for the current cycle.
    int          m_ph;
    int          m_cycles = 0;
    bit          m_s2, m_pend_v, m_end;
    logic [1:0]  m_sc;
    logic [15:0] m_r0, m_pend_d, m_addr, m_ram_a;
    logic [7:0]  m_last;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ph = 0; m_s2 = 0; m_sc = 2'b00; m_r0 = R0_RST; m_pend_v = 0;
            m_ram_a = 16'h0000; m_addr = 16'h0000; m_last = 8'h00;
        end else begin
            m_end = ce && (m_ph == 7);
            if (r0_load) begin
                if (m_s2) begin
                    m_pend_v = 1; m_pend_d = r0_din;
                end else begin
                    m_r0 = r0_din;
                end
            end
            if (m_end) begin
                if (m_s2) begin
                    m_r0 = m_pend_v ? m_pend_d : m_r0 + 16'd1;
                    m_pend_v = 0;
                    m_last = ram_f(m_addr);
                end
                m_s2 = dmao_req;
                m_sc = dmao_req ? 2'b10 : cpu_sc;
                if (dmao_req) begin
                    m_addr = m_r0; m_ram_a = m_r0;
                end
                m_cycles++;
            end
            if (ce)
                m_ph = (m_ph + 1) % 8;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                check("tpa", i, tpa[i], m_ph == 1);
                check("tpb", i, tpb[i], m_ph == 6);
                check("sc", i, sc[i], m_sc);
                check("dma_active", i, dma_active[i], m_s2);
                check("r0", i, r0[i], m_r0);
                check("ram_rd", i, ram_rd[i], m_s2 && m_ph == 2 && ce);
                check("ram_a", i, ram_a[i], m_ram_a);
                check("cpu_step", i, cpu_step[i], !m_s2 && m_ph == 7 && ce && !reset);
                if (!m_s2 || m_ph <= 2)
                    check("dma_data_hold", i, dma_data[i], m_last);
                else if (m_ph >= 6)
                    check("dma_data_tpb", i, dma_data[i], ram_f(m_addr));
                if (cpu_step[i])
                    step_cnt[i]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        tick_n++;
        case (ce_div)
            0:       ce = 1'($urandom_range(0, 1));
            1:       ce = 1'b1;
            default: ce = (tick_n % ce_div) == 0;
        endcase
    endtask

    task automatic wait_end(output int n);
        int start;
        start = m_cycles;
        n = 0;
        while (m_cycles == start && n < 400) begin
            tick();
            n++;
        end
        check("cycle_end_seen", 0, m_cycles != start, 1);
    endtask

    task automatic load_r0(input logic [15:0] v);
        r0_load = 1'b1;
        r0_din  = v;
        tick();
        r0_load = 1'b0;
    endtask

    // Holds dmao_req high for exactly n cycle boundaries, then lets the last S2 cycle finish.
    task automatic burst(input int n);
        int clks;
        dmao_req = 1'b1;
        wait_end(clks);
        step_cnt[0] = 0;
        step_cnt[1] = 0;
        for (int k = 1; k < n; k++) begin
            wait_end(clks);
            if (ce_div > 0)
                check("cycle_clks", 0, clks, 8 * ce_div);
        end
        dmao_req = 1'b0;
        wait_end(clks);
    endtask

    initial begin
        int clks;
        reset = 1'b1; ce = 1'b1; dmao_req = 1'b0; cpu_sc = 2'b01; r0_load = 1'b0; r0_din = 16'h0000;
        repeat (3) tick();
        started = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_r0", i, r0[i], 16'hC0DE);
            check("rst_sc", i, sc[i], 2'b00);
        end
        reset = 1'b0;

        // First cycle is S0, then the CPU's requested S1; one cpu_step per cycle.
        tick();
        for (int i = 0; i < 2; i++) check("first_sc", i, sc[i], 2'b00);
        wait_end(clks);
        for (int i = 0; i < 2; i++) check("second_sc", i, sc[i], 2'b01);
        step_cnt[0] = 0; step_cnt[1] = 0;
        wait_end(clks);
        wait_end(clks);
        for (int i = 0; i < 2; i++) check("steps_2cyc", i, step_cnt[i], 2);

        // Eight-cycle burst from 0x0100.
        load_r0(16'h0100);
        for (int i = 0; i < 2; i++) check("load_now", i, r0[i], 16'h0100);
        burst(8);
        for (int i = 0; i < 2; i++) begin
            check("burst_r0", i, r0[i], 16'h0108);
            check("burst_data", i, dma_data[i], 8'h07);
            check("burst_steps", i, step_cnt[i], 0);
        end

        // R0 wrap.
        load_r0(16'hFFFF);
        dmao_req = 1'b1;
        wait_end(clks);
        dmao_req = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) check("wrap_addr", i, ram_a[i], 16'hFFFF);
        wait_end(clks);
        for (int i = 0; i < 2; i++) begin
            check("wrap_r0", i, r0[i], 16'h0000);
            check("wrap_data", i, dma_data[i], 8'hFF);
        end

        // Load during S2 is deferred and overrides the increment.
        load_r0(16'h0500);
        dmao_req = 1'b1;
        wait_end(clks);
        dmao_req = 1'b0;
        repeat (3) tick();
        load_r0(16'h2000);
        for (int i = 0; i < 2; i++) begin
            check("defer_r0", i, r0[i], 16'h0500);
            check("defer_addr", i, ram_a[i], 16'h0500);
        end
        wait_end(clks);
        for (int i = 0; i < 2; i++) check("defer_done", i, r0[i], 16'h2000);

        // Sparse ce (1 in 3): same data sequence, 24 clks per cycle.
        ce_div = 3;
        load_r0(16'h0100);
        burst(8);
        for (int i = 0; i < 2; i++) begin
            check("sparse_r0", i, r0[i], 16'h0108);
            check("sparse_data", i, dma_data[i], 8'h07);
        end

        // Reset in the middle of an S2 cycle.
        ce_div = 1;
        dmao_req = 1'b1;
        wait_end(clks);
        repeat (4) tick();
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("mid_rst_r0", i, r0[i], 16'hC0DE);
            check("mid_rst_act", i, dma_active[i], 1'b0);
            check("mid_rst_data", i, dma_data[i], 8'h00);
            check("mid_rst_addr", i, ram_a[i], 16'h0000);
        end
        mode = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) check("post_rst_s0", i, sc[i], 2'b00);
        wait_end(clks);
        for (int i = 0; i < 2; i++) check("post_rst_s2", i, dma_active[i], 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            if (n % 500 == 0)
                ce_div = $urandom_range(0, 3);
            dmao_req = $urandom_range(0, 2) != 0;
            case ($urandom_range(0, 2))
                0:       cpu_sc = 2'b00;
                1:       cpu_sc = 2'b01;
                default: cpu_sc = 2'b11;
            endcase
            r0_load = $urandom_range(0, 15) == 0;
            r0_din  = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            tick();
        end
        r0_load = 1'b0;
        dmao_req = 1'b0;
        repeat (30) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
